// File: rtl/coin_beam_latch_if.sv
// Coin-chute beam sensor bus: raw pins and acknowledges in,
// sticky flags and packed coin counters out.
interface coin_beam_latch_if #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
);
   logic [NUM_CH-1:0]       sensor_in;
   logic [NUM_CH-1:0]       ack;
   logic [NUM_CH-1:0]       beam_broken;
   logic [NUM_CH-1:0]       overrun;
   logic [NUM_CH*CNT_W-1:0] coin_count;

   modport master (
      output sensor_in,
      output ack,
      input  beam_broken,
      input  overrun,
      input  coin_count
   );

   modport slave (
      input  sensor_in,
      input  ack,
      output beam_broken,
      output overrun,
      output coin_count
   );
endinterface

// File: rtl/coin_beam_latch.sv
// Coin-chute IR beam front end: sync, debounce, per-channel
// arm/clear/broken FSM, coin counters and sticky ack'd flags.
module coin_beam_latch #(
   parameter int NUM_CH          = 4,
   parameter int DEBOUNCE_CYCLES = 30000,
   parameter int CNT_W           = 16,
   parameter bit SENSE_LOW       = 1'b1
) (
   input logic               clock,
   input logic               reset,
   coin_beam_latch_if.slave  bus
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES);
   // Raw pin level of a clear beam.
   localparam logic IDLE_PIN = SENSE_LOW;

   typedef enum logic [1:0] {
      ARM,
      CLEAR,
      BROKEN
   } st_e;

   logic [NUM_CH-1:0] s1_q;
   logic [NUM_CH-1:0] s2_q;
   logic [NUM_CH-1:0] brk_s;
   logic [NUM_CH-1:0] acc_q;
   logic [NUM_CH-1:0] acc_d;
   logic [DW-1:0]     deb_q [NUM_CH];
   logic [DW-1:0]     deb_d [NUM_CH];
   st_e               st_q  [NUM_CH];
   st_e               st_d  [NUM_CH];
   logic [NUM_CH-1:0] coin;
   logic [NUM_CH-1:0] ack_q;
   logic [NUM_CH-1:0] ack_edge;
   logic [NUM_CH-1:0] bb_q;
   logic [NUM_CH-1:0] bb_d;
   logic [NUM_CH-1:0] ovr_q;
   logic [NUM_CH-1:0] ovr_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];

   // Two-flop synchroniser on the asynchronous sensor pins.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         s1_q <= {NUM_CH{IDLE_PIN}};
         s2_q <= {NUM_CH{IDLE_PIN}};
      end else begin
         s1_q <= bus.sensor_in;
         s2_q <= s1_q;
      end
   end

   assign brk_s = SENSE_LOW ? ~s2_q : s2_q;

   // Debounce: count consecutive samples that disagree with the
   // accepted level; flip the accepted level when the count hits max.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         acc_d[i] = acc_q[i];
         deb_d[i] = '0;
         if (brk_s[i] != acc_q[i]) begin
            if (deb_q[i] == DMAX) begin
               deb_d[i] = deb_q[i];
            end else begin
               deb_d[i] = deb_q[i] + DW'(1);
            end
            if (deb_d[i] == DMAX) begin
               acc_d[i] = brk_s[i];
            end
         end
      end
   end

   // Accepted level resets to "broken" so ARM only leaves once a
   // clear beam has been freshly accepted after reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q <= '1;
         for (int i = 0; i < NUM_CH; i++) begin
            deb_q[i] <= '0;
         end
      end else begin
         acc_q <= acc_d;
         for (int i = 0; i < NUM_CH; i++) begin
            deb_q[i] <= deb_d[i];
         end
      end
   end

   // Channel FSM next state; a coin is the CLEAR -> BROKEN step.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         st_d[i] = st_q[i];
         coin[i] = 1'b0;
         unique case (st_q[i])
            ARM: begin
               if (!acc_q[i]) st_d[i] = CLEAR;
            end
            CLEAR: begin
               if (acc_q[i]) begin
                  st_d[i] = BROKEN;
                  coin[i] = 1'b1;
               end
            end
            BROKEN: begin
               if (!acc_q[i]) st_d[i] = CLEAR;
            end
            default: st_d[i] = ARM;
         endcase
      end
   end

   // Channel FSM state register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i] <= ARM;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            st_q[i] <= st_d[i];
         end
      end
   end

   assign ack_edge = bus.ack & ~ack_q;

   // Flags and counters; a coin beats a same-cycle ack edge.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         bb_d[i]  = bb_q[i];
         ovr_d[i] = ovr_q[i];
         cnt_d[i] = cnt_q[i];
         if (coin[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            bb_d[i]  = 1'b1;
            if (ack_edge[i]) begin
               ovr_d[i] = 1'b0;
            end else if (bb_q[i]) begin
               ovr_d[i] = 1'b1;
            end
         end else if (ack_edge[i]) begin
            bb_d[i]  = 1'b0;
            ovr_d[i] = 1'b0;
         end
      end
   end

   // Ack history, sticky flags and coin counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ack_q <= '0;
         bb_q  <= '0;
         ovr_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         ack_q <= bus.ack;
         bb_q  <= bb_d;
         ovr_q <= ovr_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign bus.beam_broken = bb_q;
   assign bus.overrun     = ovr_q;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
      assign bus.coin_count[g*CNT_W +: CNT_W] = cnt_q[g];
   end

endmodule

// File: tb/tb_coin_beam_latch.sv
// Directed bench for coin_beam_latch: latency, glitch, ack,
// overrun, simultaneous ack/coin, blocked-at-reset, wrap, reset.
module tb_coin_beam_latch;

   logic clock;
   logic reset;
   int   n_vec;
   int   n_err;

   coin_beam_latch_if #(.NUM_CH(4), .CNT_W(16)) bus ();
   coin_beam_latch_if #(.NUM_CH(4), .CNT_W(4))  bus2 ();

   coin_beam_latch #(
      .NUM_CH(4),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(16),
      .SENSE_LOW(1'b1)
   ) u_dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   coin_beam_latch #(
      .NUM_CH(4),
      .DEBOUNCE_CYCLES(4),
      .CNT_W(4),
      .SENSE_LOW(1'b1)
   ) u_dut2 (
      .clock(clock),
      .reset(reset),
      .bus(bus2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] cnt(input int ch);
      logic [63:0] v;
      v = bus.coin_count;
      return v[ch*16 +: 16];
   endfunction

   function automatic logic [3:0] cnt2(input int ch);
      logic [15:0] v;
      v = bus2.coin_count;
      return v[ch*4 +: 4];
   endfunction

   task automatic coin(input int ch);
      bus.sensor_in[ch] = 1'b0;
      repeat (10) tick();
      bus.sensor_in[ch] = 1'b1;
      repeat (10) tick();
   endtask

   task automatic coin2(input int ch);
      bus2.sensor_in[ch] = 1'b0;
      repeat (10) tick();
      bus2.sensor_in[ch] = 1'b1;
      repeat (10) tick();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      reset = 1'b0;
      bus.sensor_in  = 4'hF;
      bus.ack        = 4'h0;
      bus2.sensor_in = 4'hF;
      bus2.ack       = 4'h0;
      #2;
      chk("rst_bb", 32'(bus.beam_broken), 32'h0);
      chk("rst_ovr", 32'(bus.overrun), 32'h0);
      chk("rst_cnt", bus.coin_count[31:0], 32'h0);
      repeat (3) tick();
      reset = 1'b1;
      repeat (10) tick();

      // single coin, latency 7 edges
      bus.sensor_in[0] = 1'b0;
      repeat (6) tick();
      chk("lat_pre", 32'(bus.beam_broken), 32'h0);
      tick();
      chk("lat_hit", 32'(bus.beam_broken), 32'h1);
      repeat (13) tick();
      bus.sensor_in[0] = 1'b1;
      repeat (10) tick();
      chk("c0_cnt", 32'(cnt(0)), 32'd1);
      bus.ack[0] = 1'b1;
      tick();
      chk("c0_ack", 32'(bus.beam_broken), 32'h0);
      bus.ack[0] = 1'b0;
      tick();

      // glitch of 3 samples
      bus.sensor_in[2] = 1'b0;
      repeat (3) tick();
      bus.sensor_in[2] = 1'b1;
      repeat (10) tick();
      chk("gl_bb", 32'(bus.beam_broken), 32'h0);
      chk("gl_cnt", 32'(cnt(2)), 32'd0);

      // two coins without ack -> overrun
      coin(1);
      coin(1);
      chk("ov_cnt", 32'(cnt(1)), 32'd2);
      chk("ov_flag", 32'(bus.overrun), 32'h2);
      chk("ov_bb", 32'(bus.beam_broken), 32'h2);
      bus.ack[1] = 1'b1;
      tick();
      chk("ak_bb", 32'(bus.beam_broken[1]), 32'h0);
      chk("ak_ovr", 32'(bus.overrun[1]), 32'h0);
      coin(1);
      chk("hold_bb", 32'(bus.beam_broken[1]), 32'h1);
      chk("hold_ovr", 32'(bus.overrun[1]), 32'h0);
      chk("hold_cnt", 32'(cnt(1)), 32'd3);
      bus.ack[1] = 1'b0;
      tick();

      // ack edge in the same cycle as a coin event
      coin(3);
      chk("sim_pre", 32'(bus.beam_broken[3]), 32'h1);
      bus.sensor_in[3] = 1'b0;
      repeat (6) tick();
      bus.ack[3] = 1'b1;
      tick();
      chk("sim_bb", 32'(bus.beam_broken[3]), 32'h1);
      chk("sim_ovr", 32'(bus.overrun[3]), 32'h0);
      chk("sim_cnt", 32'(cnt(3)), 32'd2);
      bus.sensor_in[3] = 1'b1;
      repeat (10) tick();
      bus.ack[3] = 1'b0;
      tick();

      // counter wrap on the narrow instance
      for (int k = 1; k <= 16; k++) begin
         coin2(0);
         if (k == 15) chk("wr_15", 32'(cnt2(0)), 32'd15);
      end
      chk("wr_0", 32'(cnt2(0)), 32'd0);
      chk("wr_bb", 32'(bus2.beam_broken), 32'h1);

      // async reset mid-BROKEN, beam held across release
      bus.sensor_in[0] = 1'b0;
      repeat (10) tick();
      chk("mb_bb", 32'(bus.beam_broken[0]), 32'h1);
      #3;
      reset = 1'b0;
      #1;
      chk("ar_bb", 32'(bus.beam_broken), 32'h0);
      chk("ar_ovr", 32'(bus.overrun), 32'h0);
      chk("ar_cnt", bus.coin_count[63:32], 32'h0);
      chk("ar_cnt_lo", bus.coin_count[31:0], 32'h0);
      repeat (3) tick();
      reset = 1'b1;
      repeat (20) tick();
      chk("blk_cnt", 32'(cnt(0)), 32'd0);
      chk("blk_bb", 32'(bus.beam_broken), 32'h0);
      bus.sensor_in[0] = 1'b1;
      repeat (10) tick();
      chk("blk_clr", 32'(cnt(0)), 32'd0);
      bus.sensor_in[0] = 1'b0;
      repeat (10) tick();
      chk("blk_new", 32'(cnt(0)), 32'd1);
      chk("blk_nbb", 32'(bus.beam_broken), 32'h1);
      bus.sensor_in[0] = 1'b1;
      repeat (10) tick();

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
